// File: rtl/serial_subtractor_4bit_if.sv
// Handshake and data bundle between a sequencer (master) and the bit-serial subtractor (slave).
// Signal names match the subtractor's external pin names.
interface serial_subtractor_4bit_if #(
  parameter int P_WIDTH = 4
);
  logic               iSTART;
  logic [P_WIDTH-1:0] iDATA_A;
  logic [P_WIDTH-1:0] iDATA_B;
  logic               oBUSY;
  logic               oVALID;
  logic [P_WIDTH-1:0] oDATA;
  logic               oB;

  modport master (
    output iSTART, iDATA_A, iDATA_B,
    input  oBUSY, oVALID, oDATA, oB
  );

  modport slave (
    input  iSTART, iDATA_A, iDATA_B,
    output oBUSY, oVALID, oDATA, oB
  );
endinterface

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial A - B, LSB first, one bit per clock through a single borrow flop.
// A result and its final borrow are published for one DONE cycle and then held.
module serial_subtractor_4bit #(
  parameter int P_WIDTH = 4
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  serial_subtractor_4bit_if.slave bus
);

  localparam int CNT_W = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg,  state_next;
  logic [CNT_W-1:0]   count_reg,  count_next;
  logic               borrow_reg, borrow_next;
  logic [P_WIDTH-1:0] op_a_reg,   op_a_next;
  logic [P_WIDTH-1:0] op_b_reg,   op_b_next;
  logic [P_WIDTH-1:0] res_reg,    res_next;
  logic [P_WIDTH-1:0] data_reg,   data_next;
  logic               b_reg,      b_next;

  logic               bit_a;
  logic               bit_b;
  logic               diff_bit;
  logic               borrow_out;
  logic               accept;
  logic [P_WIDTH-1:0] res_shifted;

  // Full-subtractor slice working on the current LSBs of the operand shifters.
  assign bit_a      = op_a_reg[0];
  assign bit_b      = op_b_reg[0];
  assign diff_bit   = bit_a ^ bit_b ^ borrow_reg;
  assign borrow_out = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_reg);

  // New bit enters at the MSB so that after P_WIDTH steps the LSB-first stream is in order.
  assign res_shifted = P_WIDTH'({diff_bit, res_reg} >> 1);

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    borrow_next = borrow_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    res_next    = res_reg;
    data_next   = data_reg;
    b_next      = b_reg;
    accept      = 1'b0;

    case (state_reg)
      IDLE: begin
        accept = bus.iSTART;
      end

      CALC: begin
        op_a_next   = op_a_reg >> 1;
        op_b_next   = op_b_reg >> 1;
        res_next    = res_shifted;
        borrow_next = borrow_out;
        count_next  = count_reg + 1'b1;
        if (count_reg == LAST_BIT) begin
          data_next  = res_shifted;
          b_next     = borrow_out;
          count_next = '0;
          state_next = DONE;
        end
      end

      DONE: begin
        accept     = bus.iSTART;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Acceptance is identical from IDLE and DONE, which is what allows back-to-back issue.
    if (accept) begin
      op_a_next   = bus.iDATA_A;
      op_b_next   = bus.iDATA_B;
      res_next    = '0;
      borrow_next = 1'b0;
      count_next  = '0;
      state_next  = CALC;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      borrow_reg <= 1'b0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      res_reg    <= '0;
      data_reg   <= '0;
      b_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      borrow_reg <= borrow_next;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      res_reg    <= res_next;
      data_reg   <= data_next;
      b_reg      <= b_next;
    end
  end

  // Status decodes straight from state so an asynchronous reset clears them at once.
  assign bus.oBUSY  = (state_reg == CALC);
  assign bus.oVALID = (state_reg == DONE);
  assign bus.oDATA  = data_reg;
  assign bus.oB     = b_reg;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Randomised and directed bench for serial_subtractor_4bit: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever oVALID is seen.
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic iCLOCK  = 1'b0;
  logic inRESET = 1'b0;

  serial_subtractor_4bit_if #(.P_WIDTH(W)) bus ();

  serial_subtractor_4bit #(.P_WIDTH(W)) dut (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .bus     (bus)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic [W:0]  res;
    int unsigned cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [W:0]  hold_res = '0;

  always @(posedge iCLOCK) cyc <= cyc + 1;

  // Reference: (W+1)-bit two's-complement difference of zero-extended operands.
  function automatic logic [W:0] ref_sub(input int a, input int b);
    return (W+1)'((a - b) & ((1 << (W + 1)) - 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every negedge either consumes a scoreboard entry or confirms the outputs hold.
  always @(negedge iCLOCK) begin
    if (!inRESET) begin
      check("valid_in_reset", 32'(bus.oVALID), 32'd0);
    end else if (bus.oVALID) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got oDATA=%0h oB=%0b required no pulse", bus.oDATA, bus.oB);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", 32'({bus.oB, bus.oDATA}), 32'(mon_e.res));
        check("latency", cyc - mon_e.cyc, 32'(W));
        hold_res = mon_e.res;
        $display("txn a=%0h b=%0h -> oDATA=%0h oB=%0b (ref %0h/%0b)",
                 mon_e.a, mon_e.b, bus.oDATA, bus.oB, mon_e.res[W-1:0], mon_e.res[W]);
      end
    end else begin
      check("hold", 32'({bus.oB, bus.oDATA}), 32'(hold_res));
    end
  end

  // Issue one operation starting in the current (IDLE or DONE) cycle; returns in the DONE cycle.
  // During CALC the inputs carry random junk, including iSTART, which must be ignored.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bus.iSTART  = 1'b1;
    bus.iDATA_A = a;
    bus.iDATA_B = b;
    @(posedge iCLOCK); #1;
    e.res = ref_sub(int'(a), int'(b));
    e.cyc = cyc;
    e.a   = a;
    e.b   = b;
    sb_q.push_back(e);
    check("busy_after_accept", 32'(bus.oBUSY), 32'd1);
    for (int i = 1; i <= W; i++) begin
      bus.iSTART  = 1'($urandom_range(0, 1));
      bus.iDATA_A = W'($urandom);
      bus.iDATA_B = W'($urandom);
      @(posedge iCLOCK); #1;
      check("busy_calc", 32'(bus.oBUSY), (i < W) ? 32'd1 : 32'd0);
    end
    bus.iSTART = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLOCK); #1;
      check("busy_idle", 32'(bus.oBUSY), 32'd0);
    end
  endtask

  initial begin
    bus.iSTART  = 1'b0;
    bus.iDATA_A = '0;
    bus.iDATA_B = '0;
    #1;
    check("rst_busy",  32'(bus.oBUSY),  32'd0);
    check("rst_valid", 32'(bus.oVALID), 32'd0);
    check("rst_data",  32'(bus.oDATA),  32'd0);
    check("rst_b",     32'(bus.oB),     32'd0);
    repeat (2) @(posedge iCLOCK);
    #1 inRESET = 1'b1;
    idle(1);

    issue(4'd9, 4'd3);
    idle(2);
    issue(4'd3, 4'd9);
    issue(4'd0, 4'd1);
    issue(4'hF, 4'hF);
    idle(1);
    issue(4'd5, 4'd2);
    issue(4'd2, 4'd5);
    idle(2);

    // Abort mid-CALC with an asynchronous reset; the aborted operation is never queued.
    bus.iSTART  = 1'b1;
    bus.iDATA_A = 4'd7;
    bus.iDATA_B = 4'd2;
    @(posedge iCLOCK); #1;
    bus.iSTART = 1'b0;
    @(posedge iCLOCK);
    @(posedge iCLOCK);
    #2 inRESET = 1'b0;
    #1;
    check("arst_busy",  32'(bus.oBUSY),  32'd0);
    check("arst_valid", 32'(bus.oVALID), 32'd0);
    check("arst_data",  32'(bus.oDATA),  32'd0);
    check("arst_b",     32'(bus.oB),     32'd0);
    hold_res = '0;
    @(posedge iCLOCK); #1;
    inRESET = 1'b1;
    idle(1);
    issue(4'd8, 4'd1);
    idle(1);

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        issue(W'(a), W'(b));
      end
    end
    idle(1);

    for (int k = 0; k < 40; k++) begin
      issue(W'($urandom), W'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
